// File: rtl/int_ctrl_nest.sv
// Nesting interrupt controller: edge-latched requests, priority select, PC redirect
// with pipeline flush, and a {EPC, level} return stack. `define INT_NEST_EN for nesting.
module int_ctrl_nest #(
  parameter int          N_SRC      = 4,
  parameter int          DEPTH      = 4,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
  input  logic                       in_CLK,
  input  logic                       in_RST_N,
  input  logic [N_SRC-1:0]           in_req,
  input  logic [N_SRC-1:0]           in_mask,
  input  logic                       in_ie,
  input  logic                       in_hold,
  input  logic                       in_eret,
  input  logic [31:0]                in_EPC,
  input  logic                       in_FDCLR,
  input  logic                       in_DECLR,
  output logic                       out_force,
  output logic [31:0]                out_pc,
  output logic                       out_FDCLR,
  output logic                       out_DECLR,
  output logic                       out_EECLR,
  output logic [N_SRC-1:0]           out_grant,
  output logic [$clog2(N_SRC+1)-1:0] out_level,
  output logic [$clog2(DEPTH+1)-1:0] out_depth,
  output logic                       out_NIE,
  output logic                       out_err
);

  localparam int LW = $clog2(N_SRC + 1);
  localparam int DW = $clog2(DEPTH + 1);
`ifdef INT_NEST_EN
  localparam int ED = DEPTH;
`else
  localparam int ED = 1;
`endif
  localparam int AW = (ED > 1) ? $clog2(ED) : 1;
  localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0] prev_req, pend, avail, rise, grant_vec, pend_clr;
  logic [LW-1:0]    level, cand_lvl;
  logic [DW-1:0]    depth;
  logic [IW-1:0]    cand_idx;
  logic [31:0]      cand_vec;
  logic             cand_vld, full, take, do_ret, ret_err, can_nest;
  logic [AW-1:0]    push_idx, pop_idx;
  logic [31:0]      epc_stk [ED];
  logic [LW-1:0]    lvl_stk [ED];

  assign rise  = in_req & ~prev_req;
  assign avail = pend & ~in_mask;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cand_vld  = 1'b0;
    cand_idx  = '0;
    grant_vec = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (avail[i]) begin
        cand_vld = 1'b1;
        cand_idx = IW'(i);
      end
    end
    grant_vec[cand_idx] = cand_vld;
  end

  assign cand_lvl = LW'(cand_idx) + LW'(1);
  assign cand_vec = VEC_BASE + 32'(cand_idx) * VEC_STRIDE;
  assign full     = (depth >= DW'(ED));
`ifdef INT_NEST_EN
  assign can_nest = 1'b1;
`else
  // Single-level build: a running handler is never preempted.
  assign can_nest = (level == '0);
`endif
  assign take     = cand_vld & in_ie & ~in_hold & ~in_eret & ~full & can_nest & (cand_lvl > level);
  assign do_ret   = in_eret & (depth != '0);
  assign ret_err  = in_eret & (depth == '0);
  assign pend_clr = take ? grant_vec : '0;
  assign push_idx = AW'(depth);
  assign pop_idx  = AW'(depth - DW'(1));

  // Held low during reset so every output reads zero while in_RST_N is asserted.
  assign out_NIE   = in_RST_N & in_ie & ~full & can_nest;
  assign out_level = level;
  assign out_depth = depth;

  // NOTE: the stack array has no reset; occupancy is tracked by depth, so stale entries are never read.
  always_ff @(posedge in_CLK) begin
    if (take) begin
      epc_stk[push_idx] <= in_EPC;
      lvl_stk[push_idx] <= level;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge in_CLK or negedge in_RST_N) begin
    if (!in_RST_N) begin
      prev_req  <= '0;
      pend      <= '0;
      level     <= '0;
      depth     <= '0;
      out_force <= 1'b0;
      out_pc    <= '0;
      out_grant <= '0;
      out_FDCLR <= 1'b0;
      out_DECLR <= 1'b0;
      out_EECLR <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      prev_req  <= in_req;
      // A new edge on a source being entered this cycle wins over its clear.
      pend      <= (pend & ~pend_clr) | rise;
      out_force <= 1'b0;
      out_grant <= '0;
      out_FDCLR <= in_FDCLR;
      out_DECLR <= in_DECLR;
      out_EECLR <= 1'b0;
      out_err   <= ret_err;
      if (do_ret) begin
        depth     <= depth - DW'(1);
        level     <= lvl_stk[pop_idx];
        out_pc    <= epc_stk[pop_idx];
        out_force <= 1'b1;
        out_FDCLR <= 1'b1;
        out_DECLR <= 1'b1;
        out_EECLR <= 1'b1;
      end else if (take) begin
        depth     <= depth + DW'(1);
        level     <= cand_lvl;
        out_pc    <= cand_vec;
        out_force <= 1'b1;
        out_grant <= grant_vec;
        out_FDCLR <= 1'b1;
        out_DECLR <= 1'b1;
        out_EECLR <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_int_ctrl_nest.sv
// Scenario bench for int_ctrl_nest: expected redirects are queued as stimulus is driven
// and popped by a monitor whenever out_force or out_err pulses.
module tb_int_ctrl_nest;

  localparam int N_SRC = 4;
  localparam int DEPTH = 4;

  logic        in_CLK = 1'b0, in_RST_N = 1'b1;
  logic [3:0]  in_req = '0, in_mask = '0;
  logic        in_ie = 1'b0, in_hold = 1'b0, in_eret = 1'b0;
  logic [31:0] in_EPC = '0;
  logic        in_FDCLR = 1'b0, in_DECLR = 1'b0;
  logic        out_force, out_FDCLR, out_DECLR, out_EECLR, out_NIE, out_err;
  logic [31:0] out_pc;
  logic [3:0]  out_grant;
  logic [2:0]  out_level, out_depth;

  int_ctrl_nest #(.N_SRC(N_SRC), .DEPTH(DEPTH)) dut (
    .in_CLK(in_CLK), .in_RST_N(in_RST_N), .in_req(in_req), .in_mask(in_mask),
    .in_ie(in_ie), .in_hold(in_hold), .in_eret(in_eret), .in_EPC(in_EPC),
    .in_FDCLR(in_FDCLR), .in_DECLR(in_DECLR), .out_force(out_force), .out_pc(out_pc),
    .out_FDCLR(out_FDCLR), .out_DECLR(out_DECLR), .out_EECLR(out_EECLR),
    .out_grant(out_grant), .out_level(out_level), .out_depth(out_depth),
    .out_NIE(out_NIE), .out_err(out_err)
  );

  always #5 in_CLK = ~in_CLK;

  typedef struct {
    logic        frc;
    logic        err;
    logic [31:0] pc;
    logic [3:0]  grant;
    logic [2:0]  level;
    logic [2:0]  depth;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors = 0, miscompares = 0;

  task automatic expect_ev(input logic frc, input logic err, input logic [31:0] pc,
                           input logic [3:0] grant, input logic [2:0] level, input logic [2:0] depth);
    exp_t e;
    e.frc = frc; e.err = err; e.pc = pc; e.grant = grant; e.level = level; e.depth = depth;
    sb.push_back(e);
  endtask

  // Scoreboard consumer: every redirect or error pulse must match the oldest queued expectation.
  always @(negedge in_CLK) begin
    if (in_RST_N && (out_force || out_err)) begin
      if (sb.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_event force=%b err=%b pc=%h grant=%b", out_force, out_err, out_pc, out_grant);
      end else begin
        mon_e = sb.pop_front();
        vectors++; if (out_force !== mon_e.frc) begin miscompares++; $display("FAIL ev_force got %b want %b", out_force, mon_e.frc); end
        vectors++; if (out_err !== mon_e.err) begin miscompares++; $display("FAIL ev_err got %b want %b", out_err, mon_e.err); end
        vectors++; if (out_pc !== mon_e.pc) begin miscompares++; $display("FAIL ev_pc got %h want %h", out_pc, mon_e.pc); end
        vectors++; if (out_grant !== mon_e.grant) begin miscompares++; $display("FAIL ev_grant got %b want %b", out_grant, mon_e.grant); end
        vectors++; if (out_level !== mon_e.level) begin miscompares++; $display("FAIL ev_level got %0d want %0d", out_level, mon_e.level); end
        vectors++; if (out_depth !== mon_e.depth) begin miscompares++; $display("FAIL ev_depth got %0d want %0d", out_depth, mon_e.depth); end
        if (mon_e.frc) begin
          vectors++;
          if ({out_FDCLR, out_DECLR, out_EECLR} !== 3'b111) begin
            miscompares++; $display("FAIL ev_clears got %b want 111", {out_FDCLR, out_DECLR, out_EECLR});
          end
        end
      end
    end
  end

  task automatic req_pulse(input int src);
    in_req[src] = 1'b1;
    @(negedge in_CLK);
    in_req[src] = 1'b0;
  endtask

  task automatic eret_pulse();
    in_eret = 1'b1;
    @(negedge in_CLK);
    in_eret = 1'b0;
  endtask

  // Bounded wait for the next force/err pulse; returns 99 on timeout.
  task automatic wait_pulse(output int n);
    n = 0;
    do begin
      @(negedge in_CLK);
      n++;
    end while (!(out_force || out_err) && n < 30);
    if (!(out_force || out_err)) n = 99;
  endtask

  task automatic quiet(input int cycles, output logic seen);
    seen = 1'b0;
    repeat (cycles) begin
      @(negedge in_CLK);
      if (out_force) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    #1 in_RST_N = 1'b0;
    in_ie = 1'b1;
    repeat (2) @(negedge in_CLK);
    vectors++; if (out_force !== 1'b0) begin miscompares++; $display("FAIL rst_force got %b want 0", out_force); end
    vectors++; if (out_pc !== 32'h0) begin miscompares++; $display("FAIL rst_pc got %h want 0", out_pc); end
    vectors++; if (out_grant !== 4'b0) begin miscompares++; $display("FAIL rst_grant got %b want 0", out_grant); end
    vectors++; if ({out_level, out_depth} !== 6'b0) begin miscompares++; $display("FAIL rst_lvl_dep got %0d/%0d want 0/0", out_level, out_depth); end
    vectors++; if ({out_NIE, out_err, out_FDCLR, out_DECLR, out_EECLR} !== 5'b0) begin
      miscompares++; $display("FAIL rst_flags got %b want 00000", {out_NIE, out_err, out_FDCLR, out_DECLR, out_EECLR});
    end
    in_RST_N = 1'b1;
    #1;
    vectors++; if (out_NIE !== 1'b1) begin miscompares++; $display("FAIL nie_after_rst got %b want 1", out_NIE); end
  endtask

  task automatic test_entry();
    int n;
    @(negedge in_CLK);
    in_EPC = 32'h40;
    expect_ev(1, 0, 32'h110, 4'b0010, 3'd2, 3'd1);
    req_pulse(1);
    vectors++; if (out_force !== 1'b0) begin miscompares++; $display("FAIL entry_early got %b want 0", out_force); end
    wait_pulse(n);
    vectors++; if (n !== 1) begin miscompares++; $display("FAIL entry_latency got %0d want 1", n); end
    @(negedge in_CLK);
    vectors++; if (out_force !== 1'b0) begin miscompares++; $display("FAIL entry_pulse got %b want 0", out_force); end
    vectors++; if (out_pc !== 32'h110) begin miscompares++; $display("FAIL pc_hold got %h want 110", out_pc); end
    expect_ev(1, 0, 32'h40, 4'b0000, 3'd0, 3'd0);
    eret_pulse();
    vectors++; if (out_force !== 1'b1) begin miscompares++; $display("FAIL eret_force got %b want 1", out_force); end
  endtask

  task automatic test_clears();
    @(negedge in_CLK);
    in_FDCLR = 1'b1; in_DECLR = 1'b0;
    @(negedge in_CLK);
    vectors++; if ({out_FDCLR, out_DECLR, out_EECLR} !== 3'b100) begin miscompares++; $display("FAIL clr_fd got %b want 100", {out_FDCLR, out_DECLR, out_EECLR}); end
    in_FDCLR = 1'b0; in_DECLR = 1'b1;
    @(negedge in_CLK);
    vectors++; if ({out_FDCLR, out_DECLR, out_EECLR} !== 3'b010) begin miscompares++; $display("FAIL clr_de got %b want 010", {out_FDCLR, out_DECLR, out_EECLR}); end
    in_DECLR = 1'b0;
    @(negedge in_CLK);
  endtask

  task automatic test_mask();
    int n;
    logic seen;
    in_mask = 4'b0100;
    in_EPC  = 32'hA0;
    req_pulse(2);
    quiet(5, seen);
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL masked_taken got %b want 0", seen); end
    expect_ev(1, 0, 32'h120, 4'b0100, 3'd3, 3'd1);
    in_mask = 4'b0000;
    wait_pulse(n);
    vectors++; if (n !== 1) begin miscompares++; $display("FAIL unmask_latency got %0d want 1", n); end
    expect_ev(1, 0, 32'hA0, 4'b0000, 3'd0, 3'd0);
    eret_pulse();
  endtask

  task automatic test_hold();
    int n;
    logic seen;
    @(negedge in_CLK);
    in_EPC  = 32'hB0;
    in_hold = 1'b1;
    expect_ev(1, 0, 32'h110, 4'b0010, 3'd2, 3'd1);
    req_pulse(1);
    quiet(3, seen);
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL hold_taken got %b want 0", seen); end
    in_hold = 1'b0;
    wait_pulse(n);
    vectors++; if (n !== 1) begin miscompares++; $display("FAIL hold_latency got %0d want 1", n); end
    expect_ev(1, 0, 32'hB0, 4'b0000, 3'd0, 3'd0);
    eret_pulse();
  endtask

  task automatic test_back_to_back();
    int n;
    @(negedge in_CLK);
    in_EPC = 32'hC0;
    expect_ev(1, 0, 32'h110, 4'b0010, 3'd2, 3'd1);
    req_pulse(1);
    wait_pulse(n);
    vectors++; if (n !== 1) begin miscompares++; $display("FAIL b2b_entry got %0d want 1", n); end
    in_req[3] = 1'b1;
    @(negedge in_CLK);
    in_req[3] = 1'b0;
    // src 3 is pending and eligible on the same edge as the eret; the return must win.
    in_eret = 1'b1;
    in_EPC  = 32'hD0;
    expect_ev(1, 0, 32'hC0, 4'b0000, 3'd0, 3'd0);
    expect_ev(1, 0, 32'h130, 4'b1000, 3'd4, 3'd1);
    @(negedge in_CLK);
    in_eret = 1'b0;
    vectors++; if (out_force !== 1'b1) begin miscompares++; $display("FAIL b2b_ret got %b want 1", out_force); end
    @(negedge in_CLK);
    vectors++; if (out_grant !== 4'b1000) begin miscompares++; $display("FAIL b2b_grant got %b want 1000", out_grant); end
    expect_ev(1, 0, 32'hD0, 4'b0000, 3'd0, 3'd0);
    eret_pulse();
  endtask

  task automatic test_err();
    expect_ev(0, 1, 32'hD0, 4'b0000, 3'd0, 3'd0);
    eret_pulse();
    vectors++; if ({out_err, out_force} !== 2'b10) begin miscompares++; $display("FAIL err_pulse got %b want 10", {out_err, out_force}); end
    @(negedge in_CLK);
    vectors++; if (out_err !== 1'b0) begin miscompares++; $display("FAIL err_single got %b want 0", out_err); end
  endtask

`ifdef INT_NEST_EN
  task automatic test_nesting();
    int n;
    logic seen;
    in_EPC = 32'h50;
    expect_ev(1, 0, 32'h110, 4'b0010, 3'd2, 3'd1);
    req_pulse(1);
    wait_pulse(n);
    vectors++; if (n !== 1) begin miscompares++; $display("FAIL nest_src1 got %0d want 1", n); end
    in_EPC = 32'h60;
    expect_ev(1, 0, 32'h130, 4'b1000, 3'd4, 3'd2);
    req_pulse(3);
    wait_pulse(n);
    vectors++; if (n !== 1) begin miscompares++; $display("FAIL nest_src3 got %0d want 1", n); end
    req_pulse(0);
    quiet(4, seen);
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL nest_low_taken got %b want 0", seen); end
    expect_ev(1, 0, 32'h60, 4'b0000, 3'd2, 3'd1);
    eret_pulse();
    expect_ev(1, 0, 32'h50, 4'b0000, 3'd0, 3'd0);
    in_EPC = 32'h70;
    eret_pulse();
    expect_ev(1, 0, 32'h100, 4'b0001, 3'd1, 3'd1);
    wait_pulse(n);
    vectors++; if (n !== 1) begin miscompares++; $display("FAIL nest_src0 got %0d want 1", n); end
    expect_ev(1, 0, 32'h70, 4'b0000, 3'd0, 3'd0);
    eret_pulse();
  endtask

  task automatic test_fill();
    int n;
    logic seen;
    for (int k = 0; k < 4; k++) begin
      in_EPC = 32'h200 + 32'(k * 4);
      expect_ev(1, 0, 32'h100 + 32'(k * 16), 4'(1 << k), 3'(k + 1), 3'(k + 1));
      req_pulse(k);
      wait_pulse(n);
      vectors++; if (n !== 1) begin miscompares++; $display("FAIL fill_%0d got %0d want 1", k, n); end
    end
    vectors++; if ({out_NIE, out_depth} !== 4'b0100) begin miscompares++; $display("FAIL full_nie_depth got %b/%0d want 0/4", out_NIE, out_depth); end
    req_pulse(3);
    quiet(4, seen);
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL full_taken got %b want 0", seen); end
  endtask
`else
  task automatic test_no_nest();
    int n;
    logic seen;
    in_EPC = 32'hE0;
    expect_ev(1, 0, 32'h100, 4'b0001, 3'd1, 3'd1);
    req_pulse(0);
    wait_pulse(n);
    vectors++; if (n !== 1) begin miscompares++; $display("FAIL nn_src0 got %0d want 1", n); end
    vectors++; if (out_NIE !== 1'b0) begin miscompares++; $display("FAIL nn_nie got %b want 0", out_NIE); end
    req_pulse(3);
    quiet(3, seen);
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL nn_preempt got %b want 0", seen); end
    expect_ev(1, 0, 32'hE0, 4'b0000, 3'd0, 3'd0);
    expect_ev(1, 0, 32'h130, 4'b1000, 3'd4, 3'd1);
    in_EPC = 32'hF0;
    eret_pulse();
    wait_pulse(n);
    vectors++; if (n !== 1) begin miscompares++; $display("FAIL nn_src3_after got %0d want 1", n); end
  endtask
`endif

  task automatic test_reset_mid();
    logic seen;
    @(negedge in_CLK);
    #2 in_RST_N = 1'b0;
    #1;
    vectors++; if ({out_force, out_err, out_NIE, out_FDCLR, out_DECLR, out_EECLR} !== 6'b0) begin
      miscompares++; $display("FAIL mid_rst_flags got %b want 000000", {out_force, out_err, out_NIE, out_FDCLR, out_DECLR, out_EECLR});
    end
    vectors++; if ({out_pc, out_grant} !== 36'h0) begin miscompares++; $display("FAIL mid_rst_pc got %h/%b want 0/0", out_pc, out_grant); end
    vectors++; if ({out_level, out_depth} !== 6'b0) begin miscompares++; $display("FAIL mid_rst_lvl_dep got %0d/%0d want 0/0", out_level, out_depth); end
    @(negedge in_CLK);
    in_RST_N = 1'b1;
    quiet(5, seen);
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL mid_rst_pend got %b want 0", seen); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired got running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_entry();
    test_clears();
    test_mask();
    test_hold();
    test_back_to_back();
    test_err();
`ifdef INT_NEST_EN
    test_nesting();
    test_fill();
`else
    test_no_nest();
`endif
    test_reset_mid();
    vectors++;
    if (sb.size() != 0) begin miscompares++; $display("FAIL sb_leftover got %0d want 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
